pulse_classifier: RTL

PULSE_CLASSIFIER -- requirements
Module: pulse_classifier

---
 rtl/pulse_classifier.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/pulse_classifier.sv
// Morse key front end: synchronizes and debounces a raw key, then classifies
// press lengths into dit/dash and release lengths into letter/word spaces.
module pulse_classifier #(
  parameter int UNIT_CYCLES     = 5000000,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DASH_UNITS      = 2,
  parameter int LETTER_UNITS    = 3,
  parameter int WORD_UNITS      = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  output logic [2:0] pulse_event,
  output logic       key_db
);

  typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

  localparam int PW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(UNIT_CYCLES - 1);
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]    DASH_U   = 4'(DASH_UNITS);
  localparam logic [3:0]    LETTER_U = 4'(LETTER_UNITS);
  localparam logic [3:0]    WORD_U   = 4'(WORD_UNITS);
  localparam logic [3:0]    UNITS_MAX = 4'd15;

  localparam logic [2:0] EV_NONE   = 3'd0;
  localparam logic [2:0] EV_DIT    = 3'd1;
  localparam logic [2:0] EV_DASH   = 3'd2;
  localparam logic [2:0] EV_LETTER = 3'd3;
  localparam logic [2:0] EV_WORD   = 3'd4;

  logic          sync1_reg;
  logic          sync2_reg;
  logic          key_db_reg;
  logic          key_db_prev_reg;
  logic [DW-1:0] db_cnt_reg;

  state_t        state_reg;
  logic [PW-1:0] prescaler_reg;
  logic [3:0]    press_units_reg;
  logic [3:0]    gap_units_reg;
  logic          letter_sent_reg;
  logic [2:0]    pulse_event_reg;

  logic unit_tick;
  logic db_rise;
  logic db_fall;

  assign unit_tick = (prescaler_reg == PRE_LAST);
  assign db_rise   = key_db_reg & ~key_db_prev_reg;
  assign db_fall   = ~key_db_reg & key_db_prev_reg;

  assign pulse_event = pulse_event_reg;
  assign key_db      = key_db_reg;

  // Any cycle where the synchronized key agrees with key_db restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg       <= 1'b0;
      sync2_reg       <= 1'b0;
      key_db_reg      <= 1'b0;
      key_db_prev_reg <= 1'b0;
      db_cnt_reg      <= '0;
    end else begin
      sync1_reg       <= key_in;
      sync2_reg       <= sync1_reg;
      key_db_prev_reg <= key_db_reg;
      if (sync2_reg != key_db_reg) begin
        if (db_cnt_reg == DB_LAST) begin
          key_db_reg <= sync2_reg;
          db_cnt_reg <= '0;
        end else begin
          db_cnt_reg <= db_cnt_reg + 1'b1;
        end
      end else begin
        db_cnt_reg <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      prescaler_reg   <= '0;
      press_units_reg <= '0;
      gap_units_reg   <= '0;
      letter_sent_reg <= 1'b0;
      pulse_event_reg <= EV_NONE;
    end else begin
      pulse_event_reg <= EV_NONE;
      case (state_reg)
        IDLE: begin
          prescaler_reg <= '0;
          if (db_rise) begin
            state_reg       <= PRESS;
            press_units_reg <= '0;
          end
        end

        PRESS: begin
          if (db_fall) begin
            state_reg       <= GAP;
            prescaler_reg   <= '0;
            gap_units_reg   <= '0;
            letter_sent_reg <= 1'b0;
            pulse_event_reg <= (press_units_reg < DASH_U) ? EV_DIT : EV_DASH;
          end else begin
            prescaler_reg <= unit_tick ? '0 : prescaler_reg + 1'b1;
            if (unit_tick && press_units_reg != UNITS_MAX)
              press_units_reg <= press_units_reg + 1'b1;
          end
        end

        GAP: begin
          if (db_rise) begin
            // A new press before the word space cancels whatever space is pending.
            state_reg       <= PRESS;
            prescaler_reg   <= '0;
            press_units_reg <= '0;
          end else begin
            prescaler_reg <= unit_tick ? '0 : prescaler_reg + 1'b1;
            if (unit_tick && gap_units_reg != UNITS_MAX)
              gap_units_reg <= gap_units_reg + 1'b1;
            if (gap_units_reg == WORD_U) begin
              pulse_event_reg <= EV_WORD;
              state_reg       <= IDLE;
              prescaler_reg   <= '0;
            end else if (gap_units_reg == LETTER_U && !letter_sent_reg) begin
              pulse_event_reg <= EV_LETTER;
              letter_sent_reg <= 1'b1;
            end
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
